// File: rtl/raymarch_scan_writeback_if.sv
// Bus bundle for the scan/write-back stage: the raymarcher coordinate/colour path and the framebuffer write port.
interface raymarch_scan_writeback_if;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;

    modport master (
        output pixel_x, pixel_y, wr_valid, wr_addr, wr_data,
        input  red, green, blue, wr_ready
    );

    modport slave (
        input  pixel_x, pixel_y, wr_valid, wr_addr, wr_data,
        output red, green, blue, wr_ready
    );
endinterface

// File: rtl/raymarch_scan_writeback.sv
// Raster-order frame sequencer and write-back FIFO around a fixed-latency, non-stallable raymarcher.
// Define RAYMARCH_WB_TESTPATTERN_EN to push {x[7:0], y[7:0], 8'h80} instead of the raymarcher colour.
module raymarch_scan_writeback #(
    parameter int unsigned PIPE_LATENCY = 256,
    parameter int unsigned FIFO_AW      = 4,
    parameter int unsigned FRAME_LINES  = 480
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    raymarch_scan_writeback_if.master        bus,
    output logic                             busy,
    output logic                             frame_done
);
    localparam int unsigned LINE_PIXELS = 640;
    localparam int unsigned DEPTH       = 1 << FIFO_AW;
    localparam int unsigned CW          = FIFO_AW + 1;
    localparam int unsigned SW          = FIFO_AW + 2;
    localparam int unsigned TAG_W       = 20;
    localparam int unsigned ENTRY_W     = 43;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t              state_q;
    logic [9:0]          x_q;
    logic [9:0]          y_q;
    logic [CW-1:0]       inflight_q;
    logic [CW-1:0]       count_q;
    logic [FIFO_AW-1:0]  wr_ptr_q;
    logic [FIFO_AW-1:0]  rd_ptr_q;
    logic                wr_valid_q;
    logic                busy_q;
    logic                frame_done_q;
    logic [TAG_W-1:0]    dly_q [PIPE_LATENCY];
    logic [ENTRY_W-1:0]  mem_q [DEPTH];

    logic                issue_c;
    logic                last_c;
    logic                push_c;
    logic                pop_c;
    logic [TAG_W-1:0]    tag_in_c;
    logic [TAG_W-1:0]    tag_out_c;
    logic [9:0]          tag_x_c;
    logic [8:0]          tag_y_c;
    logic [18:0]         push_addr_c;
    logic [23:0]         push_data_c;
    logic [CW-1:0]       inflight_d;
    logic [CW-1:0]       count_d;

    // Credit check on pre-update counts keeps in-flight pixels plus FIFO occupancy within the FIFO depth.
    assign issue_c   = (state_q == SCAN) &&
                       ((SW'(inflight_q) + SW'(count_q)) < SW'(DEPTH));
    assign last_c    = (x_q == 10'(LINE_PIXELS - 1)) && (y_q == 10'(FRAME_LINES - 1));
    assign tag_in_c  = {issue_c, x_q, y_q[8:0]};
    assign tag_out_c = dly_q[PIPE_LATENCY-1];
    assign tag_x_c   = tag_out_c[18:9];
    assign tag_y_c   = tag_out_c[8:0];
    assign push_c    = tag_out_c[19];
    assign pop_c     = wr_valid_q && bus.wr_ready;

    always_comb begin
        push_addr_c = (19'(tag_y_c) << 9) + (19'(tag_y_c) << 7) + 19'(tag_x_c);
`ifdef RAYMARCH_WB_TESTPATTERN_EN
        push_data_c = {tag_x_c[7:0], tag_y_c[7:0], 8'h80};
`else
        push_data_c = {bus.red, bus.green, bus.blue};
`endif
        inflight_d  = inflight_q + CW'(issue_c) - CW'(push_c);
        count_d     = count_q + CW'(push_c) - CW'(pop_c);
    end

    // Tag delay line mirrors the raymarcher latency; shifts every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(PIPE_LATENCY); i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= tag_in_c;
            for (int i = 1; i < int'(PIPE_LATENCY); i++) dly_q[i] <= dly_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= {push_addr_c, push_data_c};
        end
    end

    // Sequencer FSM, FIFO pointers/counters and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            inflight_q   <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wr_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            wr_valid_q   <= (count_d != '0);
            frame_done_q <= 1'b0;
            if (push_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);

            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= SCAN;
                        x_q     <= '0;
                        y_q     <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (issue_c) begin
                        if (x_q == 10'(LINE_PIXELS - 1)) begin
                            x_q <= '0;
                            y_q <= y_q + 10'd1;
                        end else begin
                            x_q <= x_q + 10'd1;
                        end
                        if (last_c) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Done once the post-update view shows nothing in flight and nothing buffered.
                    if ((inflight_d == '0) && (count_d == '0)) begin
                        state_q      <= IDLE;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pixel_x  = x_q;
    assign bus.pixel_y  = y_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = mem_q[rd_ptr_q][42:24];
    assign bus.wr_data  = mem_q[rd_ptr_q][23:0];
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_raymarch_scan_writeback.sv
// Directed bench for raymarch_scan_writeback on a shortened 4-line frame with a 4-cycle stub raymarcher.
module tb_raymarch_scan_writeback;
    localparam int unsigned LAT   = 4;
    localparam int unsigned AW    = 4;
    localparam int unsigned LINES = 4;
    localparam int unsigned NPIX  = 640 * LINES;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic busy;
    logic frame_done;

    raymarch_scan_writeback_if bus ();

    raymarch_scan_writeback #(
        .PIPE_LATENCY (LAT),
        .FIFO_AW      (AW),
        .FRAME_LINES  (LINES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] colour(input logic [9:0] x, input logic [9:0] y);
        return {x[7:0], x[9:8], y[5:0], 8'hA5};
    endfunction

    function automatic logic [23:0] exp_data(input int n);
        logic [9:0] x;
        logic [9:0] y;
        x = 10'(n % 640);
        y = 10'(n / 640);
`ifdef RAYMARCH_WB_TESTPATTERN_EN
        return {x[7:0], y[7:0], 8'h80};
`else
        return colour(x, y);
`endif
    endfunction

    // Stub raymarcher: LAT-stage pipeline of colour(pixel_x, pixel_y).
    logic [23:0] stub_q [LAT];
    always @(posedge clk) begin
        stub_q[0] <= colour(bus.pixel_x, bus.pixel_y);
        for (int i = 1; i < int'(LAT); i++) stub_q[i] <= stub_q[i-1];
    end
    assign bus.red   = stub_q[LAT-1][23:16];
    assign bus.green = stub_q[LAT-1][15:8];
    assign bus.blue  = stub_q[LAT-1][7:0];

    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.wr_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Write monitor: in-order address/data scoreboard, stall-hold check, frame_done counter.
    int          wr_cnt = 0;
    int          fd_cnt = 0;
    time         last_wr_time = 0;
    logic [18:0] log_addr [NPIX];
    logic [23:0] log_data [NPIX];
    logic        prev_stall = 1'b0;
    logic [18:0] prev_addr = '0;
    logic [23:0] prev_data = '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) fd_cnt++;
            if (prev_stall) begin
                check("hold_valid", 32'(bus.wr_valid), 32'd1);
                check("hold_addr", 32'(bus.wr_addr), 32'(prev_addr));
                check("hold_data", 32'(bus.wr_data), 32'(prev_data));
            end
            if (bus.wr_valid && bus.wr_ready) begin
                if (wr_cnt < int'(NPIX)) begin
                    log_addr[wr_cnt] = bus.wr_addr;
                    log_data[wr_cnt] = bus.wr_data;
                    check("wr_addr_order", 32'(bus.wr_addr), 32'(wr_cnt));
                    check("wr_data_model", 32'(bus.wr_data), 32'(exp_data(wr_cnt)));
                end else begin
                    check("write_overrun", 32'(wr_cnt), 32'(NPIX - 1));
                end
                wr_cnt++;
                last_wr_time = $time;
            end
            prev_stall = bus.wr_valid && !bus.wr_ready;
            prev_addr  = bus.wr_addr;
            prev_data  = bus.wr_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    typedef struct {
        int unsigned x;
        int unsigned y;
        logic [18:0] addr;
        logic [23:0] data_rgb;
        logic [23:0] data_tp;
    } vec_t;

    vec_t vecs [8];

    task automatic start_frame();
        wr_cnt = 0;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic wait_frame_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_pixel_x"},    32'(bus.pixel_x), 32'd0);
        check({pfx, "_pixel_y"},    32'(bus.pixel_y), 32'd0);
        check({pfx, "_wr_valid"},   32'(bus.wr_valid), 32'd0);
        check({pfx, "_wr_addr"},    32'(bus.wr_addr), 32'd0);
        check({pfx, "_wr_data"},    32'(bus.wr_data), 32'd0);
        check({pfx, "_busy"},       32'(busy), 32'd0);
        check({pfx, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        int lat;
        int fd_before;
        int idx;
        logic [23:0] want;

        vecs[0] = '{0,   0, 19'd0,    24'h0000A5, 24'h000080};
        vecs[1] = '{1,   0, 19'd1,    24'h0100A5, 24'h010080};
        vecs[2] = '{639, 0, 19'd639,  24'h7F80A5, 24'h7F0080};
        vecs[3] = '{0,   1, 19'd640,  24'h0001A5, 24'h000180};
        vecs[4] = '{5,   1, 19'd645,  24'h0501A5, 24'h050180};
        vecs[5] = '{320, 2, 19'd1600, 24'h4042A5, 24'h400280};
        vecs[6] = '{5,   3, 19'd1925, 24'h0503A5, 24'h050380};
        vecs[7] = '{639, 3, 19'd2559, 24'h7F83A5, 24'h7F0380};

        reset = 1'b1;
        enable = 1'b0;
        bus.wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);

        // Frame 1: always-ready sink, latency and completion timing.
        bus.wr_ready = 1'b1;
        start_frame();
        check("scan_busy", 32'(busy), 32'd1);
        check("scan_first_x", 32'(bus.pixel_x), 32'd0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.wr_valid) begin
                lat = k;
                break;
            end
        end
        check("first_wr_valid_latency", 32'(lat), 32'(LAT + 1));
        wait_frame_done(4000, "f1");
        check("f1_busy_in_done_cycle", 32'(busy), 32'd1);
        check("f1_done_after_last_write", 32'($time - last_wr_time), 32'd10);
        check("f1_drain_no_issue_x", 32'(bus.pixel_x), 32'd0);
        check("f1_drain_no_issue_y", 32'(bus.pixel_y), 32'(LINES));
        @(negedge clk);
        check("f1_done_pulse_width", 32'(frame_done), 32'd0);
        check("f1_busy_after_done", 32'(busy), 32'd0);
        check("f1_write_count", 32'(wr_cnt), 32'(NPIX));
        check("f1_done_count", 32'(fd_cnt), 32'd1);

        for (int i = 0; i < 8; i++) begin
            idx = int'(vecs[i].y) * 640 + int'(vecs[i].x);
`ifdef RAYMARCH_WB_TESTPATTERN_EN
            want = vecs[i].data_tp;
`else
            want = vecs[i].data_rgb;
`endif
            check($sformatf("vec%0d_addr", i), 32'(log_addr[idx]), 32'(vecs[i].addr));
            check($sformatf("vec%0d_data", i), 32'(log_data[idx]), 32'(want));
        end

        repeat (20) @(negedge clk);
        check("f1_no_stale_writes", 32'(wr_cnt), 32'(NPIX));
        check("f1_idle_busy", 32'(busy), 32'd0);

        // Frame 2: sink stalled from the start, then random readiness.
        bus.wr_ready = 1'b0;
        start_frame();
        repeat (40) @(posedge clk);
        #1;
        check("stall_pixel_x", 32'(bus.pixel_x), 32'd16);
        check("stall_pixel_y", 32'(bus.pixel_y), 32'd0);
        check("stall_wr_valid", 32'(bus.wr_valid), 32'd1);
        check("stall_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("stall_wr_data", 32'(bus.wr_data), 32'(exp_data(0)));
        repeat (10) @(posedge clk);
        #1;
        check("stall_hold_pixel_x", 32'(bus.pixel_x), 32'd16);
        check("stall_hold_wr_addr", 32'(bus.wr_addr), 32'd0);
        rand_ready = 1'b1;
        wait_frame_done(20000, "f2");
        rand_ready = 1'b0;
        @(negedge clk);
        bus.wr_ready = 1'b1;
        check("f2_write_count", 32'(wr_cnt), 32'(NPIX));
        check("f2_done_count", 32'(fd_cnt), 32'd2);

        // Frame 3: asynchronous reset after 1000 issues aborts silently.
        start_frame();
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if ((int'(bus.pixel_y) * 640 + int'(bus.pixel_x)) >= 1000) break;
        end
        check("abort_reached_1000", 32'(int'(bus.pixel_y) * 640 + int'(bus.pixel_x)), 32'd1000);
        fd_before = fd_cnt;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_cnt = 0;
        repeat (300) @(posedge clk);
        #1;
        check("abort_no_writes", 32'(wr_cnt), 32'd0);
        check("abort_no_done", 32'(fd_cnt), 32'(fd_before));
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_valid", 32'(bus.wr_valid), 32'd0);

        // Frame 4: restart after abort begins at address 0 and completes.
        start_frame();
        wait_frame_done(4000, "f4");
        @(negedge clk);
        check("f4_write_count", 32'(wr_cnt), 32'(NPIX));
        check("f4_done_count", 32'(fd_cnt), 32'(fd_before + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
